iob_ram2p_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives the write and read ports of an external two-port RAM (one write port, one registered read port, `2**ADDR_W` words). It owns the pointers, level count and full/empty flags, and exposes a push/pop interface to the user logic. The parent instantiates the RAM next to this block and connects the `ext_mem_*` ports directly to it. Intended as the standard buffer front-end for streaming peripherals.

---
 rtl/iob_ram2p_fifo_ctrl_pkg.sv | 17 +
 rtl/iob_ram2p_fifo_ctrl.sv | 93 +++++++++
 tb/tb_iob_ram2p_fifo_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/iob_ram2p_fifo_ctrl_pkg.sv
// Shared types for the two-port-RAM FIFO controller: level update selection.
package iob_ram2p_fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      LVL_HOLD = 2'd0,
      LVL_INC  = 2'd1,
      LVL_DEC  = 2'd2
   } level_op_e;

   // A simultaneous push and pop leaves the level unchanged.
   function automatic level_op_e level_op(input logic push, input logic pop);
      if (push && !pop) return LVL_INC;
      if (pop && !push) return LVL_DEC;
      return LVL_HOLD;
   endfunction

endpackage

// File: rtl/iob_ram2p_fifo_ctrl.sv
// Synchronous FIFO controller driving an external two-port RAM with a
// registered read port; owns pointers, level and full/empty flags.
module iob_ram2p_fifo_ctrl
   import iob_ram2p_fifo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              w_en_i,
   input  logic [DATA_W-1:0] w_data_i,
   output logic              w_full_o,
   input  logic              r_en_i,
   output logic [DATA_W-1:0] r_data_o,
   output logic              r_valid_o,
   output logic              r_empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              overflow_o,
   output logic              underflow_o,
   output logic              ext_mem_w_en_o,
   output logic [ADDR_W-1:0] ext_mem_w_addr_o,
   output logic [DATA_W-1:0] ext_mem_w_data_o,
   output logic              ext_mem_r_en_o,
   output logic [ADDR_W-1:0] ext_mem_r_addr_o,
   input  logic [DATA_W-1:0] ext_mem_r_data_i
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              r_valid_q, r_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              push_ok, pop_ok;

   // Flags decode from the registered level only, so a push into an empty
   // FIFO can never fall through to a pop in the same cycle.
   always_comb begin
      w_full_o  = (level_q == DEPTH);
      r_empty_o = (level_q == '0);
      push_ok   = w_en_i & ~w_full_o;
      pop_ok    = r_en_i & ~r_empty_o;
   end

   always_comb begin
      wptr_d      = push_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_d      = pop_ok  ? rptr_q + 1'b1 : rptr_q;
      level_d     = level_q;
      case (level_op(push_ok, pop_ok))
         LVL_INC: level_d = level_q + 1'b1;
         LVL_DEC: level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      r_valid_d   = pop_ok;
      overflow_d  = w_en_i & w_full_o;
      underflow_d = r_en_i & r_empty_o;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         r_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         r_valid_q   <= r_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      ext_mem_w_en_o   = push_ok;
      ext_mem_w_addr_o = wptr_q;
      ext_mem_w_data_o = w_data_i;
      ext_mem_r_en_o   = pop_ok;
      ext_mem_r_addr_o = rptr_q;
      r_data_o         = ext_mem_r_data_i;
      r_valid_o        = r_valid_q;
      level_o          = level_q;
      overflow_o       = overflow_q;
      underflow_o      = underflow_q;
   end

endmodule

// File: tb/tb_iob_ram2p_fifo_ctrl.sv
// Self-checking bench for iob_ram2p_fifo_ctrl (depth 4) with a behavioural
// two-port RAM and a data scoreboard.
module tb_iob_ram2p_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       w_en = 1'b0;
   logic [7:0] w_data = '0;
   logic       r_en = 1'b0;
   logic       w_full_o, r_empty_o, r_valid_o, overflow_o, underflow_o;
   logic [7:0] r_data_o;
   logic [2:0] level_o;
   logic       mw_en, mr_en;
   logic [1:0] mw_addr, mr_addr;
   logic [7:0] mw_data, ram_rdata;
   logic [7:0] mem [4];

   int unsigned total = 0;
   int unsigned bad = 0;

   logic [7:0] sb[$];
   logic [2:0] m_level = '0;
   logic [1:0] m_wptr = '0;
   logic [1:0] m_rptr = '0;
   logic       m_valid = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mw_en) mem[mw_addr] <= mw_data;
      if (mr_en) ram_rdata <= mem[mr_addr];
   end

   iob_ram2p_fifo_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .w_en_i(w_en), .w_data_i(w_data), .w_full_o(w_full_o),
      .r_en_i(r_en), .r_data_o(r_data_o), .r_valid_o(r_valid_o),
      .r_empty_o(r_empty_o), .level_o(level_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o),
      .ext_mem_w_en_o(mw_en), .ext_mem_w_addr_o(mw_addr), .ext_mem_w_data_o(mw_data),
      .ext_mem_r_en_o(mr_en), .ext_mem_r_addr_o(mr_addr), .ext_mem_r_data_i(ram_rdata)
   );

   task automatic model_clear();
      m_level = '0; m_wptr = '0; m_rptr = '0;
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      sb.delete();
   endtask

   // One clock of stimulus: checks the combinational RAM port against the
   // model before the edge, then registered outputs and scoreboard after it.
   task automatic drive_cycle(input logic we, input logic [7:0] wd, input logic re);
      logic       exp_push, exp_pop;
      logic [7:0] exp_data;
      w_en = we; w_data = wd; r_en = re;
      exp_push = we && (m_level != 3'd4);
      exp_pop  = re && (m_level != 3'd0);
      #1;
      total++; if (mw_en !== exp_push) begin bad++; $display("FAIL mem_w_en got=%b exp=%b", mw_en, exp_push); end
      total++; if (mr_en !== exp_pop) begin bad++; $display("FAIL mem_r_en got=%b exp=%b", mr_en, exp_pop); end
      total++; if (w_full_o !== (m_level == 3'd4)) begin bad++; $display("FAIL full got=%b lvl=%0d", w_full_o, m_level); end
      total++; if (r_empty_o !== (m_level == 3'd0)) begin bad++; $display("FAIL empty got=%b lvl=%0d", r_empty_o, m_level); end
      if (exp_push) begin
         total++; if (mw_addr !== m_wptr || mw_data !== wd) begin
            bad++; $display("FAIL mem_w_port addr=%0d data=%h exp addr=%0d data=%h", mw_addr, mw_data, m_wptr, wd);
         end
      end
      if (exp_pop) begin
         total++; if (mr_addr !== m_rptr) begin bad++; $display("FAIL mem_r_addr got=%0d exp=%0d", mr_addr, m_rptr); end
      end
      @(posedge clk);
      if (exp_push) sb.push_back(wd);
      m_ovf   = we && (m_level == 3'd4);
      m_udf   = re && (m_level == 3'd0);
      m_valid = exp_pop;
      if (exp_push) m_wptr = m_wptr + 2'd1;
      if (exp_pop)  m_rptr = m_rptr + 2'd1;
      if (exp_push && !exp_pop) m_level = m_level + 3'd1;
      if (exp_pop && !exp_push) m_level = m_level - 3'd1;
      #1;
      w_en = 1'b0; r_en = 1'b0;
      total++; if (r_valid_o !== m_valid) begin bad++; $display("FAIL r_valid got=%b exp=%b", r_valid_o, m_valid); end
      total++; if (overflow_o !== m_ovf) begin bad++; $display("FAIL overflow got=%b exp=%b", overflow_o, m_ovf); end
      total++; if (underflow_o !== m_udf) begin bad++; $display("FAIL underflow got=%b exp=%b", underflow_o, m_udf); end
      total++; if (level_o !== m_level) begin bad++; $display("FAIL level got=%0d exp=%0d", level_o, m_level); end
      if (r_valid_o === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL r_data unexpected word got=%h exp=none", r_data_o);
         end else begin
            exp_data = sb.pop_front();
            if (r_data_o !== exp_data) begin bad++; $display("FAIL r_data got=%h exp=%h", r_data_o, exp_data); end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      total++; if (r_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", r_empty_o); end
      total++; if (w_full_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", w_full_o); end
      total++; if (level_o !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_o); end
      total++; if (r_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", r_valid_o); end
      total++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
         bad++; $display("FAIL reset_pulses ovf=%b udf=%b exp=0", overflow_o, underflow_o);
      end
   endtask

   task automatic test_fill_drain();
      logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, words[i], 1'b0);
      drive_cycle(1'b1, 8'h55, 1'b0);
      total++; if (w_full_o !== 1'b1 || level_o !== 3'd4) begin
         bad++; $display("FAIL fill_full full=%b level=%0d exp full=1 level=4", w_full_o, level_o);
      end
      total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b exp=1", overflow_o); end
      total++; if (mem[0] !== 8'h11) begin bad++; $display("FAIL fill_ram0 got=%h exp=11", mem[0]); end
      drive_cycle(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b1);
      drive_cycle(1'b0, 8'h00, 1'b0);
      total++; if (r_empty_o !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", r_empty_o); end
   endtask

   task automatic test_underflow();
      logic [1:0] rptr_before;
      rptr_before = m_rptr;
      drive_cycle(1'b0, 8'h00, 1'b1);
      total++; if (underflow_o !== 1'b1 || r_valid_o !== 1'b0) begin
         bad++; $display("FAIL underflow_pulse udf=%b valid=%b exp udf=1 valid=0", underflow_o, r_valid_o);
      end
      total++; if (mr_addr !== rptr_before || level_o !== 3'd0) begin
         bad++; $display("FAIL underflow_state raddr=%0d level=%0d exp raddr=%0d level=0", mr_addr, level_o, rptr_before);
      end
      drive_cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_wrap();
      drive_cycle(1'b1, 8'hE0, 1'b0);
      drive_cycle(1'b1, 8'hE1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, 8'(i), 1'b1);
         total++; if (level_o !== 3'd2) begin bad++; $display("FAIL wrap_level i=%0d got=%0d exp=2", i, level_o); end
      end
      drive_cycle(1'b0, 8'h00, 1'b1);
      drive_cycle(1'b0, 8'h00, 1'b1);
      drive_cycle(1'b0, 8'h00, 1'b0);
      total++; if (r_empty_o !== 1'b1 || sb.size() != 0) begin
         bad++; $display("FAIL wrap_drain empty=%b left=%0d exp empty=1 left=0", r_empty_o, sb.size());
      end
   endtask

   task automatic test_simultaneous();
      drive_cycle(1'b1, 8'hAA, 1'b1);
      total++; if (level_o !== 3'd1 || r_valid_o !== 1'b0) begin
         bad++; $display("FAIL sim_empty level=%0d valid=%b exp level=1 valid=0", level_o, r_valid_o);
      end
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
      drive_cycle(1'b1, 8'hCC, 1'b1);
      total++; if (level_o !== 3'd3 || overflow_o !== 1'b1 || r_valid_o !== 1'b1) begin
         bad++; $display("FAIL sim_full level=%0d ovf=%b valid=%b exp level=3 ovf=1 valid=1", level_o, overflow_o, r_valid_o);
      end
   endtask

   task automatic test_reset_mid_pop();
      drive_cycle(1'b0, 8'h00, 1'b1);
      rst_n = 1'b0; r_en = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1; r_en = 1'b0;
      model_clear();
      total++; if (r_valid_o !== 1'b0) begin bad++; $display("FAIL midpop_valid got=%b exp=0", r_valid_o); end
      total++; if (level_o !== 3'd0 || r_empty_o !== 1'b1) begin
         bad++; $display("FAIL midpop_level level=%0d empty=%b exp level=0 empty=1", level_o, r_empty_o);
      end
      drive_cycle(1'b1, 8'h5A, 1'b0);
      drive_cycle(1'b0, 8'h00, 1'b1);
      drive_cycle(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_underflow();
      test_wrap();
      test_simultaneous();
      test_reset_mid_pop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
